// File: rtl/arith_pkg.sv
// Shared encodings for the multi-cycle arithmetic execute stage.
// Covers opcode values, FSM states and the default operand width.
package arith_pkg;

  localparam int SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/arith_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the
// way in, and negation of product / quotient / remainder on the way out.
module arith_sign_fix
  import arith_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            signed_op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] a_mag,
  output logic [SIZE-1:0] b_mag,
  output logic            a_neg,
  output logic            b_neg,
  input  logic            is_mul,
  input  logic            neg_res,
  input  logic            neg_rem,
  input  logic [SIZE-1:0] raw_hi,
  input  logic [SIZE-1:0] raw_lo,
  output logic [SIZE-1:0] fix_hi,
  output logic [SIZE-1:0] fix_lo
);

  logic [2*SIZE-1:0] prod;

  always_comb begin
    a_neg = signed_op & a[SIZE-1];
    b_neg = signed_op & b[SIZE-1];
    // The most negative value maps to 2^(SIZE-1), which still fits unsigned.
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    prod = neg_res ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
    if (is_mul) begin
      fix_hi = prod[2*SIZE-1:SIZE];
      fix_lo = prod[SIZE-1:0];
    end else begin
      fix_lo = neg_res ? -raw_lo : raw_lo;
      fix_hi = neg_rem ? -raw_hi : raw_hi;
    end
  end

endmodule

// File: rtl/arith_exec_seq.sv
// Execute stage: single-cycle add/sub, SIZE-step shift-add multiply and
// restoring divide, with a valid/ready handshake on both sides.
module arith_exec_seq
  import arith_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int CNT_W = $clog2(SIZE) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            signed_op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result_lo,
  output logic [SIZE-1:0] result_hi,
  output logic            div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  hi_q, hi_d;
  logic [SIZE-1:0]  lo_q, lo_d;
  logic [SIZE-1:0]  opb_q, opb_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  res_lo_q, res_lo_d;
  logic [SIZE-1:0]  res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;

  logic [SIZE-1:0]  a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [SIZE:0]    mul_sum;
  logic [SIZE:0]    rem_sh;
  logic [SIZE-1:0]  rem_diff;
  logic             div_ge;
  logic [SIZE-1:0]  step_hi, step_lo;
  logic [SIZE-1:0]  fix_hi, fix_lo;

  arith_sign_fix #(.SIZE(SIZE)) u_sign_fix (
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .is_mul    (state_q == ST_MUL),
    .neg_res   (neg_res_q),
    .neg_rem   (neg_rem_q),
    .raw_hi    (step_hi),
    .raw_lo    (step_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  // hi/lo double as {product high, multiplier} for MUL and as
  // {partial remainder, dividend-shifting-into-quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {hi_q, lo_q[SIZE-1]};
    div_ge   = rem_sh >= {1'b0, opb_q};
    rem_diff = rem_sh[SIZE-1:0] - opb_q;
    if (state_q == ST_MUL) begin
      step_hi = mul_sum[SIZE:1];
      step_lo = {mul_sum[0], lo_q[SIZE-1:1]};
    end else begin
      step_hi = div_ge ? rem_diff : rem_sh[SIZE-1:0];
      step_lo = {lo_q[SIZE-2:0], div_ge};
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    out_valid_d = out_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hi_d      = '0;
          lo_d      = a_mag;
          opb_d     = b_mag;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          unique case (op_e'(op))
            OP_ADD: begin
              res_lo_d    = a + b;
              res_hi_d    = '0;
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
            OP_SUB: begin
              res_lo_d    = a - b;
              res_hi_d    = '0;
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
            OP_MUL: state_d = ST_MUL;
            OP_DIV: begin
              if (b == '0) begin
                res_lo_d    = '1;
                res_hi_d    = a;
                dbz_d       = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
              end else begin
                state_d = ST_DIV;
              end
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        // The final step's raw value goes through sign correction directly.
        if (cnt_q == CNT_W'(SIZE - 1)) begin
          res_lo_d    = fix_lo;
          res_hi_d    = fix_hi;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_exec_seq.sv
// Bench for arith_exec_seq: directed vectors with literal expectations plus a
// per-cycle comparison against a plain-arithmetic reference model.
module tb_arith_exec_seq;

  localparam int SIZE = 32;
  localparam int LONG = SIZE + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      op = 2'b00;
  logic            signed_op = 1'b0;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] result_lo;
  logic [SIZE-1:0] result_hi;
  logic            div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int pushes = 0;
  int pops = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b0;

  typedef struct {
    logic [SIZE-1:0] lo;
    logic [SIZE-1:0] hi;
    logic            dbz;
    int              lat;
    int              acc;
  } want_t;

  want_t want_q[$];

  arith_exec_seq #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .signed_op   (signed_op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: wide integer arithmetic; SV '/' and '%' truncate toward zero.
  function automatic want_t model(input logic [1:0] o, input logic s,
                                  input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                  input int acc);
    want_t  w;
    longint sx, sy, q, r, p;
    w.acc = acc;
    w.dbz = 1'b0;
    w.hi  = '0;
    w.lat = 1;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    case (o)
      2'b00: w.lo = x + y;
      2'b01: w.lo = x - y;
      2'b10: begin
        p     = sx * sy;
        w.lo  = p[31:0];
        w.hi  = p[63:32];
        w.lat = LONG;
      end
      default: begin
        if (y == '0) begin
          w.lo  = '1;
          w.hi  = x;
          w.dbz = 1'b1;
        end else begin
          q     = sx / sy;
          r     = sx % sy;
          w.lo  = q[31:0];
          w.hi  = r[31:0];
          w.lat = LONG;
        end
      end
    endcase
    return w;
  endfunction

  // Single compare process: every cycle with out_valid is checked against the
  // oldest outstanding expectation; a handshake retires it.
  always @(negedge clk) begin
    want_t w;
    if (rst) begin
      want_q.delete();
      pushes = 0;
      pops   = 0;
    end else begin
      if (out_valid) begin
        check("out_valid_vs_in_ready", in_ready, 0);
        if (want_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          w = want_q[0];
          if (w.lat >= 0) begin
            check("model_latency", cyc - w.acc, w.lat);
            want_q[0].lat = -1;
          end
          check("model_lo", result_lo, w.lo);
          check("model_hi", result_hi, w.hi);
          check("model_dbz", div_by_zero, w.dbz);
          if (out_ready) begin
            void'(want_q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) begin
        want_q.push_back(model(op, signed_op, a, b, cyc));
        pushes++;
      end
    end
  end

  task automatic run_dir(input string name, input logic [1:0] o, input logic s,
                         input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                         input logic [SIZE-1:0] exp_lo, input logic [SIZE-1:0] exp_hi,
                         input logic exp_dbz, input int exp_lat, input int hold);
    int t0;
    int n;
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    op = o; signed_op = s; a = x; b = y; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({name, "_accept"}, in_ready, 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); signed_op = ~s;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check({name, "_latency"}, cyc - t0, exp_lat);
    check({name, "_lo"}, result_lo, exp_lo);
    check({name, "_hi"}, result_hi, exp_hi);
    check({name, "_dbz"}, div_by_zero, exp_dbz);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_held_valid"}, out_valid, 1);
      check({name, "_held_in_ready"}, in_ready, 0);
      check({name, "_held_lo"}, result_lo, exp_lo);
    end
    ready_force = 1'b1;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 10) begin @(negedge clk); n++; end
    check({name, "_retired"}, out_valid, 0);
    check({name, "_kept_lo"}, result_lo, exp_lo);
    ready_force = 1'b0;
  endtask

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_lo", result_lo, 0);
    check("reset_hi", result_hi, 0);
    check("reset_dbz", div_by_zero, 0);

    run_dir("add_wrap",   2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b0, 1,    3);
    run_dir("mul_s_neg",  2'b10, 1'b1, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, LONG, 1);
    run_dir("mul_u_max",  2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, LONG, 0);
    run_dir("mul_s_min",  2'b10, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 1'b0, LONG, 0);
    run_dir("div_s_neg",  2'b11, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LONG, 0);
    run_dir("div_u",      2'b11, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, LONG, 2);
    run_dir("div_zero",   2'b11, 1'b0, 32'h1234,      32'h0,         32'hFFFF_FFFF, 32'h1234,      1'b1, 1,    1);
    run_dir("add_after0", 2'b00, 1'b1, 32'd5,         32'd6,         32'd11,        32'h0,         1'b0, 1,    0);
    run_dir("div_s_ovf",  2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, LONG, 0);
    run_dir("sub_u",      2'b01, 1'b0, 32'd3,         32'd5,         32'hFFFF_FFFE, 32'h0,         1'b0, 1,    0);

    // Reset during the 10th iteration of a multiply discards it entirely.
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    op = 2'b10; signed_op = 1'b0; a = 32'h1234_5678; b = 32'h9; in_valid = 1'b1;
    @(negedge clk);
    check("rst_mul_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_lo", result_lo, 0);
    check("rst_mid_hi", result_hi, 0);
    repeat (40) @(negedge clk);
    check("rst_no_stale_result", out_valid, 0);
    ready_force = 1'b0;

    // Back-to-back random stream with random writeback stalls.
    rand_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      op        = 2'($urandom_range(0, 3));
      signed_op = 1'($urandom_range(0, 1));
      a         = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'h1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(2, 300));
        default: b = $urandom;
      endcase
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      check("stream_accept", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (want_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("stream_drained", want_q.size(), 0);
    check("stream_retired_count", pops, 20);
    check("stream_push_pop_balance", pops, pushes);
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
